rf_write_sched: RTL and testbench



---
 rtl/rf_write_sched_if.sv | 36 +++
 rtl/rf_write_sched.sv | 189 ++++++++++++++++++
 tb/tb_rf_write_sched.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_sched_if.sv
// Write-port scheduler bundle: ALU and load-return request
// channels, ALU flush, RF write port and busy scoreboard.
//   master: request producer / RF consumer (drives requests)
//   slave : scheduler (drives rdy, we/wn/wd, busy)
interface rf_write_sched_if #(
    parameter int WIDTH = 32
);
    logic             alu_v;
    logic             alu_rdy;
    logic [4:0]       alu_rn;
    logic             alu_jal;
    logic [WIDTH-1:0] alu_d;
    logic             mem_v;
    logic             mem_rdy;
    logic [4:0]       mem_rn;
    logic [WIDTH-1:0] mem_d;
    logic             flush;
    logic             we;
    logic [4:0]       wn;
    logic [WIDTH-1:0] wd;
    logic [31:0]      busy;

    modport master (
        output alu_v, alu_rn, alu_jal, alu_d,
        output mem_v, mem_rn, mem_d, flush,
        input  alu_rdy, mem_rdy,
        input  we, wn, wd, busy
    );

    modport slave (
        input  alu_v, alu_rn, alu_jal, alu_d,
        input  mem_v, mem_rn, mem_d, flush,
        output alu_rdy, mem_rdy,
        output we, wn, wd, busy
    );
endinterface

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: two request FIFOs
// (ALU/link, load return), arbitration onto one RF write port
// and a pending-write scoreboard for the hazard unit.
//   clk   : rising-edge clock
//   clrn  : asynchronous active-low reset
//   bus   : rf_write_sched_if.slave
//     alu_v/alu_rdy/alu_rn/alu_jal/alu_d : ALU request channel
//     mem_v/mem_rdy/mem_rn/mem_d         : load request channel
//     flush                              : drop ALU-side work
//     we/wn/wd                           : registered RF write
//     busy                               : pending-write bits
module rf_write_sched #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             clrn,
    rf_write_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // ALU FIFO
    logic [4:0]       a_rn [DEPTH];
    logic [WIDTH-1:0] a_d  [DEPTH];
    logic [AW-1:0]    a_rp;
    logic [AW-1:0]    a_wp;
    logic [CW-1:0]    a_cnt;

    // MEM FIFO
    logic [4:0]       m_rn [DEPTH];
    logic [WIDTH-1:0] m_d  [DEPTH];
    logic [AW-1:0]    m_rp;
    logic [AW-1:0]    m_wp;
    logic [CW-1:0]    m_cnt;

    // 0: ALU granted last, 1: MEM granted last
    logic last;

    logic             we_q;
    logic [4:0]       wn_q;
    logic [WIDTH-1:0] wd_q;

    logic             a_push;
    logic             m_push;
    logic             a_head_v;
    logic             m_head_v;
    logic [4:0]       a_head_rn;
    logic [4:0]       m_head_rn;
    logic             gnt_a;
    logic             gnt_m;
    logic             gnt;
    logic [4:0]       g_rn;
    logic [WIDTH-1:0] g_d;
    logic [31:0]      busy_c;
    logic [AW-1:0]    off;

    assign bus.alu_rdy = (a_cnt < FULL);
    assign bus.mem_rdy = (m_cnt < FULL);

    // A flushed cycle never stores the incoming ALU request.
    assign a_push = bus.alu_v & bus.alu_rdy & ~bus.flush;
    assign m_push = bus.mem_v & bus.mem_rdy;

    assign a_head_v  = (a_cnt != '0) & ~bus.flush;
    assign m_head_v  = (m_cnt != '0);
    assign a_head_rn = a_rn[a_rp];
    assign m_head_rn = m_rn[m_rp];

    // Same destination: the load is older, so it goes first.
    // Otherwise MEM wins only if ALU was granted last.
    assign gnt_m = m_head_v
                 & (~a_head_v
                    | (a_head_rn == m_head_rn)
                    | ~last);
    assign gnt_a = a_head_v & ~gnt_m;
    assign gnt   = gnt_a | gnt_m;
    assign g_rn  = gnt_m ? m_head_rn : a_head_rn;
    assign g_d   = gnt_m ? m_d[m_rp] : a_d[a_rp];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            a_rp  <= '0;
            a_wp  <= '0;
            a_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_rn[i] <= '0;
                a_d[i]  <= '0;
            end
        end else if (bus.flush) begin
            a_rp  <= '0;
            a_wp  <= '0;
            a_cnt <= '0;
        end else begin
            if (a_push) begin
                a_rn[a_wp] <= bus.alu_rn | {5{bus.alu_jal}};
                a_d[a_wp]  <= bus.alu_d;
                a_wp       <= a_wp + 1'b1;
            end
            if (gnt_a) begin
                a_rp <= a_rp + 1'b1;
            end
            a_cnt <= a_cnt
                   + {{(CW-1){1'b0}}, a_push}
                   - {{(CW-1){1'b0}}, gnt_a};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_rp  <= '0;
            m_wp  <= '0;
            m_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                m_rn[i] <= '0;
                m_d[i]  <= '0;
            end
        end else begin
            if (m_push) begin
                m_rn[m_wp] <= bus.mem_rn;
                m_d[m_wp]  <= bus.mem_d;
                m_wp       <= m_wp + 1'b1;
            end
            if (gnt_m) begin
                m_rp <= m_rp + 1'b1;
            end
            m_cnt <= m_cnt
                   + {{(CW-1){1'b0}}, m_push}
                   - {{(CW-1){1'b0}}, gnt_m};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last <= 1'b0;
        end else if (gnt_a) begin
            last <= 1'b0;
        end else if (gnt_m) begin
            last <= 1'b1;
        end
    end

    // r0 grants still dequeue but never pulse we; wn
    // reports 0 and wd keeps its previous value.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we_q <= 1'b0;
            wn_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= gnt & (g_rn != '0);
            if (gnt) begin
                wn_q <= g_rn;
                if (g_rn != '0) begin
                    wd_q <= g_d;
                end
            end
        end
    end

    assign bus.we = we_q;
    assign bus.wn = wn_q;
    assign bus.wd = wd_q;

    // A slot is live when its distance from the read
    // pointer is below the occupancy count.
    always_comb begin
        busy_c = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - a_rp;
            if ({1'b0, off} < a_cnt) begin
                busy_c[a_rn[i]] = 1'b1;
            end
            off = AW'(i) - m_rp;
            if ({1'b0, off} < m_cnt) begin
                busy_c[m_rn[i]] = 1'b1;
            end
        end
        if (we_q) begin
            busy_c[wn_q] = 1'b1;
        end
        busy_c[0] = 1'b0;
    end

    assign bus.busy = busy_c;

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: directed scenarios
// plus randomized traffic against a queue-based model.
module tb_rf_write_sched;
    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic clrn;

    always #5 clk = ~clk;

    rf_write_sched_if #(.WIDTH(WIDTH)) bus();

    rf_write_sched #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // reference model: per-source queues + RR bit + write port
    logic [4:0]  qa_rn[$];
    logic [31:0] qa_d[$];
    logic [4:0]  qm_rn[$];
    logic [31:0] qm_d[$];
    bit          m_last;   // 0: ALU last, 1: MEM last
    logic        m_we;
    logic [4:0]  m_wn;
    logic [31:0] m_wd;

    task automatic model_reset();
        qa_rn.delete();
        qa_d.delete();
        qm_rn.delete();
        qm_d.delete();
        m_last = 1'b0;
        m_we   = 1'b0;
        m_wn   = '0;
        m_wd   = '0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (qa_rn[k]) b[qa_rn[k]] = 1'b1;
        foreach (qm_rn[k]) b[qm_rn[k]] = 1'b1;
        if (m_we) b[m_wn] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic set_idle();
        bus.alu_v   = 1'b0;
        bus.alu_rn  = '0;
        bus.alu_jal = 1'b0;
        bus.alu_d   = '0;
        bus.mem_v   = 1'b0;
        bus.mem_rn  = '0;
        bus.mem_d   = '0;
        bus.flush   = 1'b0;
    endtask

    // Advance one clock with the inputs currently driven,
    // stepping the model alongside; returns on the negedge.
    task automatic tick();
        bit          a_acc;
        bit          m_acc;
        bit          a_ok;
        bit          m_ok;
        bit          g_m;
        bit          g_a;
        logic [4:0]  g_rn;
        logic [31:0] g_d;
        logic        n_we;
        logic [4:0]  n_wn;
        logic [31:0] n_wd;
        a_acc = (bus.alu_v === 1'b1) && (qa_rn.size() < DEPTH);
        m_acc = (bus.mem_v === 1'b1) && (qm_rn.size() < DEPTH);
        a_ok  = (qa_rn.size() > 0) && (bus.flush !== 1'b1);
        m_ok  = (qm_rn.size() > 0);
        if (a_ok && m_ok) begin
            if (qa_rn[0] == qm_rn[0]) g_m = 1'b1;
            else g_m = (m_last == 1'b0);
        end else begin
            g_m = m_ok;
        end
        g_a  = a_ok && !g_m;
        n_we = 1'b0;
        n_wn = m_wn;
        n_wd = m_wd;
        if (g_m || g_a) begin
            if (g_m) begin
                g_rn = qm_rn.pop_front();
                g_d  = qm_d.pop_front();
            end else begin
                g_rn = qa_rn.pop_front();
                g_d  = qa_d.pop_front();
            end
            m_last = g_m;
            n_wn   = g_rn;
            if (g_rn != 0) begin
                n_we = 1'b1;
                n_wd = g_d;
            end
        end
        if (bus.flush === 1'b1) begin
            qa_rn.delete();
            qa_d.delete();
        end else if (a_acc) begin
            qa_rn.push_back(bus.alu_rn | {5{bus.alu_jal}});
            qa_d.push_back(bus.alu_d);
        end
        if (m_acc) begin
            qm_rn.push_back(bus.mem_rn);
            qm_d.push_back(bus.mem_d);
        end
        @(posedge clk);
        m_we = n_we;
        m_wn = n_wn;
        m_wd = n_wd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        set_idle();
        clrn = 1'b0;
        #13;
        n_checks++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd0 || bus.wd !== 32'd0) begin
            n_err++;
            $display("FAIL reset_out: we=%b wn=%0d wd=%h, required 0 0 0",
                     bus.we, bus.wn, bus.wd);
        end
        n_checks++;
        if (bus.busy !== 32'd0 || bus.alu_rdy !== 1'b1 || bus.mem_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status: busy=%h rdy=%b%b, required 0 11",
                     bus.busy, bus.alu_rdy, bus.mem_rdy);
        end
        do_reset();
    endtask

    task automatic test_single_alu();
        int bcnt = 0;
        int wcnt = 0;
        do_reset();
        bus.alu_v  = 1'b1;
        bus.alu_rn = 5'd5;
        bus.alu_d  = 32'h1234;
        tick();
        set_idle();
        for (int i = 0; i < 6; i++) begin
            if (bus.busy[5] === 1'b1) bcnt++;
            if (bus.we === 1'b1) begin
                wcnt++;
                n_checks++;
                if (i != 1 || bus.wn !== 5'd5 || bus.wd !== 32'h1234) begin
                    n_err++;
                    $display("FAIL single_write: cyc=%0d wn=%0d wd=%h, required cyc=1 wn=5 wd=00001234",
                             i, bus.wn, bus.wd);
                end
            end
            tick();
        end
        n_checks++;
        if (wcnt != 1) begin
            n_err++;
            $display("FAIL single_pulses: got %0d, required 1", wcnt);
        end
        n_checks++;
        if (bcnt != 2) begin
            n_err++;
            $display("FAIL single_busy_len: got %0d, required 2", bcnt);
        end
    endtask

    task automatic test_jal();
        do_reset();
        bus.alu_v   = 1'b1;
        bus.alu_rn  = 5'd0;
        bus.alu_jal = 1'b1;
        bus.alu_d   = 32'h0040_0008;
        tick();
        set_idle();
        n_checks++;
        if (bus.busy !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL jal_busy: got %h, required 80000000", bus.busy);
        end
        tick();
        n_checks++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd31 || bus.wd !== 32'h0040_0008) begin
            n_err++;
            $display("FAIL jal_write: we=%b wn=%0d wd=%h, required 1 31 00400008",
                     bus.we, bus.wn, bus.wd);
        end
        tick();
        n_checks++;
        if (bus.we !== 1'b0 || bus.busy !== 32'd0) begin
            n_err++;
            $display("FAIL jal_done: we=%b busy=%h, required 0 0", bus.we, bus.busy);
        end
    endtask

    task automatic test_contention();
        logic [4:0] exp_wn [4];
        exp_wn[0] = 5'd8;
        exp_wn[1] = 5'd3;
        exp_wn[2] = 5'd9;
        exp_wn[3] = 5'd4;
        do_reset();
        bus.alu_v  = 1'b1;
        bus.alu_rn = 5'd3;
        bus.alu_d  = 32'hA3;
        bus.mem_v  = 1'b1;
        bus.mem_rn = 5'd8;
        bus.mem_d  = 32'hB8;
        tick();
        bus.alu_rn = 5'd4;
        bus.alu_d  = 32'hA4;
        bus.mem_rn = 5'd9;
        bus.mem_d  = 32'hB9;
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.we !== 1'b1 || bus.wn !== exp_wn[i]) begin
                n_err++;
                $display("FAIL rr_order[%0d]: we=%b wn=%0d, required 1 %0d",
                         i, bus.we, bus.wn, exp_wn[i]);
            end
            tick();
        end
        bus.alu_v  = 1'b1;
        bus.alu_rn = 5'd7;
        bus.alu_d  = 32'hAAAA_0007;
        bus.mem_v  = 1'b1;
        bus.mem_rn = 5'd7;
        bus.mem_d  = 32'hBBBB_0007;
        tick();
        set_idle();
        tick();
        n_checks++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd7 || bus.wd !== 32'hBBBB_0007) begin
            n_err++;
            $display("FAIL same_rn_first: we=%b wn=%0d wd=%h, required 1 7 bbbb0007",
                     bus.we, bus.wn, bus.wd);
        end
        tick();
        n_checks++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd7 || bus.wd !== 32'hAAAA_0007) begin
            n_err++;
            $display("FAIL same_rn_second: we=%b wn=%0d wd=%h, required 1 7 aaaa0007",
                     bus.we, bus.wn, bus.wd);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int          m_n = 0;
        int          a_n = 0;
        int          n_at_drop = -1;
        logic [31:0] m_log[$];
        logic [31:0] a_log[$];
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (bus.we === 1'b1) begin
                if (bus.wd[31:16] == 16'hBEEF) m_log.push_back(bus.wd);
                else a_log.push_back(bus.wd);
            end
            bus.mem_v  = (m_n < 6);
            bus.mem_rn = 5'(16 + m_n);
            bus.mem_d  = 32'hBEEF_0000 | 32'(m_n);
            bus.alu_v  = (a_n < 6);
            bus.alu_rn = 5'(1 + a_n);
            bus.alu_d  = 32'hA11C_0000 | 32'(a_n);
            if (bus.mem_v && bus.mem_rdy !== 1'b1 && n_at_drop < 0)
                n_at_drop = m_n;
            if (bus.mem_v && bus.mem_rdy === 1'b1) m_n++;
            if (bus.alu_v && bus.alu_rdy === 1'b1) a_n++;
            tick();
        end
        set_idle();
        n_checks++;
        if (n_at_drop < DEPTH) begin
            n_err++;
            $display("FAIL bp_rdy_drop: accepts before drop=%0d, required >=%0d",
                     n_at_drop, DEPTH);
        end
        n_checks++;
        if (m_log.size() != 6 || a_log.size() != 6) begin
            n_err++;
            $display("FAIL bp_count: mem=%0d alu=%0d, required 6 6",
                     m_log.size(), a_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (m_log[k] !== (32'hBEEF_0000 | 32'(k))
                    || a_log[k] !== (32'hA11C_0000 | 32'(k))) begin
                    n_err++;
                    $display("FAIL bp_data[%0d]: mem=%h alu=%h, required %h %h",
                             k, m_log[k], a_log[k],
                             32'hBEEF_0000 | 32'(k), 32'hA11C_0000 | 32'(k));
                end
            end
        end
    endtask

    task automatic test_r0_flush();
        do_reset();
        bus.alu_v  = 1'b1;
        bus.alu_rn = 5'd0;
        bus.alu_d  = 32'hDEAD;
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.we !== 1'b0 || bus.busy !== 32'd0) begin
                n_err++;
                $display("FAIL r0_write: cyc=%0d we=%b busy=%h, required 0 0",
                         i, bus.we, bus.busy);
            end
            tick();
        end
        bus.alu_v  = 1'b1;
        bus.alu_rn = 5'd10;
        bus.alu_d  = 32'h10;
        bus.mem_v  = 1'b1;
        bus.mem_rn = 5'd2;
        bus.mem_d  = 32'hC0DE;
        tick();
        bus.mem_v  = 1'b0;
        bus.alu_rn = 5'd11;
        bus.alu_d  = 32'h11;
        tick();
        n_checks++;
        if (bus.busy[11:10] !== 2'b11) begin
            n_err++;
            $display("FAIL flush_pre_busy: busy=%h, required bits 10,11 set", bus.busy);
        end
        n_checks++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd2 || bus.wd !== 32'hC0DE) begin
            n_err++;
            $display("FAIL flush_mem_write: we=%b wn=%0d wd=%h, required 1 2 0000c0de",
                     bus.we, bus.wn, bus.wd);
        end
        bus.flush  = 1'b1;
        bus.alu_rn = 5'd12;
        bus.alu_d  = 32'h12;
        tick();
        set_idle();
        n_checks++;
        if (bus.busy[12:10] !== 3'b000) begin
            n_err++;
            $display("FAIL flush_busy: busy=%h, required bits 10..12 clear", bus.busy);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.we !== 1'b0) begin
                n_err++;
                $display("FAIL flush_stale: cyc=%0d we=%b wn=%0d, required we=0",
                         i, bus.we, bus.wn);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.alu_v  = 1'b1;
        bus.alu_rn = 5'd20;
        bus.alu_d  = 32'h20;
        bus.mem_v  = 1'b1;
        bus.mem_rn = 5'd22;
        bus.mem_d  = 32'h22;
        tick();
        bus.alu_rn = 5'd21;
        bus.alu_d  = 32'h21;
        bus.mem_rn = 5'd23;
        bus.mem_d  = 32'h23;
        tick();
        set_idle();
        n_checks++;
        if (bus.we !== 1'b1 || bus.busy === 32'd0) begin
            n_err++;
            $display("FAIL arst_pre: we=%b busy=%h, required we=1 busy!=0",
                     bus.we, bus.busy);
        end
        #2;
        clrn = 1'b0;
        #1;
        n_checks++;
        if (bus.we !== 1'b0 || bus.busy !== 32'd0
            || bus.alu_rdy !== 1'b1 || bus.mem_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL arst_now: we=%b busy=%h rdy=%b%b, required 0 0 11",
                     bus.we, bus.busy, bus.alu_rdy, bus.mem_rdy);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.we !== 1'b0 || bus.busy !== 32'd0) begin
                n_err++;
                $display("FAIL arst_stale: cyc=%0d we=%b busy=%h, required 0 0",
                         i, bus.we, bus.busy);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] eb;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            n_checks++;
            if (bus.we !== m_we || bus.wn !== m_wn || bus.wd !== m_wd) begin
                n_err++;
                $display("FAIL rnd_port: cyc=%0d we/wn/wd=%b/%0d/%h, required %b/%0d/%h",
                         c, bus.we, bus.wn, bus.wd, m_we, m_wn, m_wd);
            end
            eb = model_busy();
            n_checks++;
            if (bus.busy !== eb) begin
                n_err++;
                $display("FAIL rnd_busy: cyc=%0d got %h, required %h", c, bus.busy, eb);
            end
            n_checks++;
            if (bus.alu_rdy !== (qa_rn.size() < DEPTH)
                || bus.mem_rdy !== (qm_rn.size() < DEPTH)) begin
                n_err++;
                $display("FAIL rnd_rdy: cyc=%0d got %b%b, required %b%b",
                         c, bus.alu_rdy, bus.mem_rdy,
                         qa_rn.size() < DEPTH, qm_rn.size() < DEPTH);
            end
            bus.alu_v   = ($urandom_range(0, 3) != 0);
            bus.alu_rn  = 5'($urandom_range(0, 7));
            bus.alu_jal = ($urandom_range(0, 7) == 0);
            bus.alu_d   = $urandom;
            bus.mem_v   = ($urandom_range(0, 2) != 0);
            bus.mem_rn  = 5'($urandom_range(0, 7));
            bus.mem_d   = $urandom;
            bus.flush   = ($urandom_range(0, 15) == 0);
            tick();
        end
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        clrn = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_jal();
        test_contention();
        test_backpressure();
        test_r0_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
